// File: rtl/piso_shift_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_shift_serializer_pkg;

    // Two-state controller encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Bit-counter width able to hold the value WIDTH
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_shift_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
interface piso_shift_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_last;

    // Upstream word source / serial consumer side
    modport master (
        output load_valid, parallel_in,
        input  load_ready, serial_out, serial_valid, frame_start, frame_last
    );

    // Serializer side
    modport slave (
        input  load_valid, parallel_in,
        output load_ready, serial_out, serial_valid, frame_start, frame_last
    );
endinterface

// File: rtl/piso_shift_serializer_core.sv
// Shift register datapath: parallel load, zero-filled shift toward the output end.
module piso_shift_serializer_core
    import piso_shift_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_sreg;

    // Load takes priority; otherwise shift with zero fill so the register empties by frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            if (MSB_FIRST) begin
                r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
            end else begin
                r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
            end
        end
    end

    assign o_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

endmodule

// File: rtl/piso_shift_serializer.sv
// Serializer top: load handshake, frame controller and bit counter around the shift core.
module piso_shift_serializer
    import piso_shift_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   clear,
    piso_shift_serializer_if.slave bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_start;
    logic          w_start_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          w_load_ready;
    logic          w_accept;
    logic          w_load;
    logic          w_shift;
    logic          w_bit;

    // Ready only from registered state: idle, or on the last bit of a frame
    assign w_load_ready = (r_state == ST_IDLE) ||
                          ((r_state == ST_SHIFT) && (r_count == CW'(1)));
    assign w_accept     = bus.load_valid && w_load_ready;

    // Controller state and registered frame flags
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
            r_start <= w_start_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state, counter and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_valid_nxt = r_valid;
        w_start_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        if (w_accept) begin
            // New frame, from IDLE or chained straight off the last bit
            w_state_nxt = ST_SHIFT;
            w_count_nxt = CW'(WIDTH);
            w_valid_nxt = 1'b1;
            w_start_nxt = 1'b1;
            w_last_nxt  = 1'b0;
            w_load      = 1'b1;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    w_shift = 1'b1;
                    if (r_count == CW'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_count_nxt = r_count - CW'(1);
                        w_last_nxt  = (r_count == CW'(2));
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    piso_shift_serializer_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk     (clk),
        .rst     (clear),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (bus.parallel_in),
        .o_bit   (w_bit)
    );

    assign bus.load_ready   = w_load_ready;
    assign bus.serial_out   = w_bit && r_valid;
    assign bus.serial_valid = r_valid;
    assign bus.frame_start  = r_start;
    assign bus.frame_last   = r_last;

endmodule

// File: tb/tb_piso_shift_serializer.sv
// Directed bench: MSB-first and LSB-first serializers driven in parallel.
module tb_piso_shift_serializer;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    piso_shift_serializer_if #(.WIDTH(4)) if_a ();
    piso_shift_serializer_if #(.WIDTH(4)) if_b ();

    piso_shift_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .clear (clear),
        .bus   (if_a)
    );

    piso_shift_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .clear (clear),
        .bus   (if_b)
    );

    // Left-shift SIPO receiver fed by the MSB-first stream
    logic [3:0] sipo = 4'b0000;
    always @(posedge clk) begin
        if (if_a.serial_valid) sipo <= {sipo[2:0], if_a.serial_out};
    end

    // exp_* list the serial bits with the first-sent bit at index 3
    typedef struct {
        logic [3:0] word;
        logic [3:0] exp_msb;
        logic [3:0] exp_lsb;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        if_a.load_valid  = v;
        if_a.parallel_in = d;
        if_b.load_valid  = v;
        if_b.parallel_in = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " a valid"}, 32'(if_a.serial_valid), 32'd0);
        chk({tag, " a out"},   32'(if_a.serial_out),   32'd0);
        chk({tag, " a start"}, 32'(if_a.frame_start),  32'd0);
        chk({tag, " a last"},  32'(if_a.frame_last),   32'd0);
        chk({tag, " a ready"}, 32'(if_a.load_ready),   32'd1);
        chk({tag, " b valid"}, 32'(if_b.serial_valid), 32'd0);
        chk({tag, " b out"},   32'(if_b.serial_out),   32'd0);
        chk({tag, " b ready"}, 32'(if_b.load_ready),   32'd1);
    endtask

    // One frame on both DUTs from idle, checked bit by bit, then idle and loopback
    task automatic run_frame(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        drive(1'b1, v.word);
        chk({t, " ready before load"}, 32'(if_a.load_ready), 32'd1);
        next_cycle();
        drive(1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            string s;
            s = $sformatf("%s bit%0d", t, k);
            chk({s, " a out"},   32'(if_a.serial_out),   32'(v.exp_msb[3-k]));
            chk({s, " b out"},   32'(if_b.serial_out),   32'(v.exp_lsb[3-k]));
            chk({s, " a valid"}, 32'(if_a.serial_valid), 32'd1);
            chk({s, " b valid"}, 32'(if_b.serial_valid), 32'd1);
            chk({s, " a start"}, 32'(if_a.frame_start),  32'(k == 0));
            chk({s, " a last"},  32'(if_a.frame_last),   32'(k == 3));
            chk({s, " b last"},  32'(if_b.frame_last),   32'(k == 3));
            chk({s, " a ready"}, 32'(if_a.load_ready),   32'(k == 3));
            next_cycle();
        end
        chk_idle({t, " after"});
        chk({t, " loopback"}, 32'(sipo), 32'(v.word));
    endtask

    initial begin
        logic [7:0] b2b;
        logic [3:0] one;

        vecs[0] = '{word: 4'b1011, exp_msb: 4'b1011, exp_lsb: 4'b1101};
        vecs[1] = '{word: 4'b0000, exp_msb: 4'b0000, exp_lsb: 4'b0000};
        vecs[2] = '{word: 4'b1111, exp_msb: 4'b1111, exp_lsb: 4'b1111};
        vecs[3] = '{word: 4'b1001, exp_msb: 4'b1001, exp_lsb: 4'b1001};
        vecs[4] = '{word: 4'b0110, exp_msb: 4'b0110, exp_lsb: 4'b0110};
        vecs[5] = '{word: 4'b0101, exp_msb: 4'b0101, exp_lsb: 4'b1010};

        // Reset
        clear = 1'b1;
        drive(1'b0, 4'b0000);
        #2;
        chk_idle("reset");
        next_cycle();
        clear = 1'b0;
        chk_idle("post reset");

        // Table-driven single frames with loopback
        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        // Back-to-back: 1011 then 0110 with load_valid held high
        b2b = 8'b1011_0110;
        drive(1'b1, 4'b1011);
        next_cycle();
        drive(1'b1, 4'b0110);
        for (int k = 0; k < 8; k++) begin
            string s;
            s = $sformatf("b2b bit%0d", k);
            chk({s, " out"},   32'(if_a.serial_out),   32'(b2b[7-k]));
            chk({s, " valid"}, 32'(if_a.serial_valid), 32'd1);
            chk({s, " start"}, 32'(if_a.frame_start),  32'((k == 0) || (k == 4)));
            chk({s, " last"},  32'(if_a.frame_last),   32'((k == 3) || (k == 7)));
            chk({s, " ready"}, 32'(if_a.load_ready),   32'((k == 3) || (k == 7)));
            next_cycle();
            if (k == 3) drive(1'b0, 4'b0000);
        end
        chk_idle("b2b after");
        chk("b2b loopback", 32'(sipo), 32'h6);

        // Busy load of 1111 during the 1011 frame is ignored
        one = 4'b1011;
        drive(1'b1, one);
        next_cycle();
        drive(1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy bit%0d out", k), 32'(if_a.serial_out), 32'(one[3-k]));
            chk($sformatf("busy bit%0d start", k), 32'(if_a.frame_start), 32'(k == 0));
            if (k == 1) drive(1'b1, 4'b1111);
            if (k == 2) drive(1'b0, 4'b0000);
            next_cycle();
        end
        chk_idle("busy after");
        chk("busy loopback", 32'(sipo), 32'hB);
        next_cycle();
        chk_idle("busy idle2");

        // Asynchronous clear in the middle of a frame
        drive(1'b1, 4'b1011);
        next_cycle();
        drive(1'b0, 4'b0000);
        chk("midrst bit0", 32'(if_a.serial_out), 32'd1);
        next_cycle();
        chk("midrst bit1", 32'(if_a.serial_out), 32'd0);
        next_cycle();
        chk("midrst pre valid", 32'(if_a.serial_valid), 32'd1);
        #3;
        clear = 1'b1;
        #1;
        chk_idle("midrst async");
        next_cycle();
        chk_idle("midrst held");
        clear = 1'b0;
        run_frame(vecs[5], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_serializer.md
Name: piso_shift_serializer

Overview:
- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per clock.
- Sits upstream of the team's left-shifting SIPO receivers. The default bit order is MSB first, so after WIDTH shifts a left-shift receiver holds the original word.
- Supports back-to-back words with no idle gap between frames.

Parameters:
- WIDTH, 4, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, selects bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream has a word on parallel_in.
- load_ready  output  1  serializer can accept a word this cycle.
- parallel_in  input  WIDTH  word to send; sampled only on an accepted load.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of each frame.
- frame_last  output  1  high with the last bit of each frame.

Behaviour:
- Reset (clear high, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - serial_out=0, serial_valid=0, frame_start=0, frame_last=0, load_ready=1.
  - Reset mid-frame abandons the frame immediately; no further bits are emitted.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame bits being emitted.
- Accept: a load occurs on a rising edge where load_valid && load_ready.
- load_ready is combinational from registered state only: load_ready = (state==IDLE) || (state==SHIFT && count==1).
  - It never depends on load_valid.
  - load_valid while load_ready=0 is ignored and the word is not captured.
- Latency: the first bit appears on serial_out in the cycle after the accept edge, i.e. it is registered. WIDTH bits occupy WIDTH consecutive cycles.
- On accept:
  - Shift register <= parallel_in; count <= WIDTH; state <= SHIFT.
  - Registered outputs: serial_out = the first bit, serial_valid=1, frame_start=1.
- Each SHIFT cycle edge:
  - Register shifts toward the output end: left for MSB_FIRST=1, right for MSB_FIRST=0, zero fill.
  - count decrements; frame_start clears after one cycle.
- frame_last=1 while count==1, i.e. during the last bit.
- At the end of the last-bit cycle:
  - If a load is accepted, start the new frame with no gap (same as accept from IDLE).
  - Otherwise go to IDLE: serial_valid=0, serial_out=0.
- WIDTH=2: frame_start and frame_last occupy adjacent cycles.
- Bit counter width is $clog2(WIDTH+1). The counter never wraps: it never goes below 1 in SHIFT and is reloaded or idled at 1.
- serial_out is 0 whenever serial_valid=0.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE, SHIFT)
  - counter-width function or constant derived from WIDTH
- Optional sub-module piso_shift_core:
  - holds the shift register only (load, shift, direction per MSB_FIRST, output bit)
  - FSM, counter and handshake stay in the top module

Test Plan:
- Reset then single frame (WIDTH=4, MSB_FIRST=1):
  - Stimulus: load 4'b1011 at edge N.
  - Response: serial_out=1,0,1,1 on cycles N+1..N+4, serial_valid high for exactly those cycles, frame_start at N+1, frame_last at N+4, load_ready low N+1..N+3.
- Back-to-back frames:
  - Stimulus: 4'b1011, then 4'b0110 presented with load_valid held high.
  - Response: 8 contiguous valid bits 1,0,1,1,0,1,1,0; second accept occurs on the frame_last cycle; no idle cycle between frames.
- Busy load ignored:
  - Stimulus: pulse load_valid with 4'b1111 at N+2 during the 4'b1011 frame.
  - Response: output stream unchanged (1,0,1,1); returns to IDLE after N+4; 4'b1111 is never emitted.
- LSB-first (MSB_FIRST=0):
  - Stimulus: load 4'b1011.
  - Response: serial_out=1,1,0,1.
- Mid-frame reset:
  - Stimulus: assert clear asynchronously between edges N+2 and N+3.
  - Response: serial_valid, frame_start and frame_last drop immediately; load_ready=1; the next load of 4'b0101 is emitted cleanly as 0,1,0,1.
- Loopback:
  - Stimulus: drive a bench 4-bit left-shift SIPO model from serial_out, clocked only when serial_valid, for words 0000, 1111, 1001, 0110.
  - Response: on frame_last+1 the model holds each original word.
